// File: rtl/aes_pkg.sv
// Shared AES-128 constants and byte-level helpers for the encrypt datapath.
// Byte 0 is bits [127:120]; the state is column-major (bytes 0-3 form column 0).
package aes_pkg;

    localparam int NR_128 = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Out-of-range round numbers (IDLE, post-final) map to a zero constant.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 1; i <= 10; i++)
            if (r == i[3:0]) v = RCON[i];
        return v;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%4)) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = gmul2(a0) ^ gmul3(a1) ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ gmul2(a1) ^ gmul3(a2) ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ gmul2(a2) ^ gmul3(a3);
            r[103-32*c -: 8] = gmul3(a0) ^ a1 ^ a2 ^ gmul2(a3);
        end
        return r;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = rk;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encrypt round: SubBytes, ShiftRows, MixColumns
// (bypassed on the final round) and AddRoundKey.
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] round_key_i,
    input  logic         final_i,
    output logic [127:0] state_o
);

    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;

    always_comb begin
        sb = '0;
        for (int i = 0; i < 16; i++)
            sb[127-8*i -: 8] = sbox(state_i[127-8*i -: 8]);
        sr = shift_rows(sb);
        mc = final_i ? sr : mix_columns(sr);
        state_o = mc ^ round_key_i;
    end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock, round key expanded on the fly.
// Handshake: start is taken on an edge where busy=0; done pulses one cycle with ciphertext valid.
module aes_encrypt_iter
    import aes_pkg::*;
#(
    parameter int NR = NR_128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic [127:0] ciphertext
);

    if (NR != NR_128) begin : g_bad_nr
        $error("aes_encrypt_iter supports only NR=10 (AES-128)");
    end

    fsm_e         fsm_q, fsm_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] ct_q, ct_d;
    logic         done_q, done_d;

    logic [127:0] rk_next;
    logic [127:0] round_out;
    logic         final_rnd;

    assign rk_next   = key_step(rk_q, rcon(rnd_q));
    assign final_rnd = (rnd_q == 4'(NR));

    aes_enc_round u_round (
        .state_i     (blk_q),
        .round_key_i (rk_next),
        .final_i     (final_rnd),
        .state_o     (round_out)
    );

    always_comb begin
        fsm_d  = fsm_q;
        blk_d  = blk_q;
        rk_d   = rk_q;
        rnd_d  = rnd_q;
        ct_d   = ct_q;
        done_d = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (start) begin
                    blk_d = plaintext ^ key;
                    rk_d  = key;
                    rnd_d = 4'd1;
                    fsm_d = ST_RUN;
                end
            end
            ST_RUN: begin
                blk_d = round_out;
                rk_d  = rk_next;
                rnd_d = rnd_q + 4'd1;
                if (final_rnd) begin
                    ct_d   = round_out;
                    done_d = 1'b1;
                    fsm_d  = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q  <= ST_IDLE;
            blk_q  <= '0;
            rk_q   <= '0;
            rnd_q  <= '0;
            ct_q   <= '0;
            done_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            blk_q  <= blk_d;
            rk_q   <= rk_d;
            rnd_q  <= rnd_d;
            ct_q   <= ct_d;
            done_q <= done_d;
        end
    end

    assign busy       = (fsm_q == ST_RUN);
    assign done       = done_q;
    assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: byte-array AES reference with self-derived S-box,
// cycle-by-cycle output compare, FIPS-197 vectors, decrypt round-trip.
module tb_aes_encrypt_iter;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] CT_0   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    typedef logic [0:175][7:0] ks_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic [127:0] ciphertext;

    int checks   = 0;
    int failures = 0;

    logic [127:0] exp_q[$];
    logic [127:0] pt_q[$];
    logic [127:0] key_q[$];
    logic [7:0]   sb_t  [256];
    logic [7:0]   isb_t [256];

    bit           m_live = 1'b0;
    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;
    int           m_left = 0;
    logic [127:0] m_ct   = '0;

    always #5 clk = ~clk;

    aes_encrypt_iter dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .plaintext  (plaintext),
        .key        (key),
        .busy       (busy),
        .done       (done),
        .ciphertext (ciphertext)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    function automatic void build_tables();
        logic [7:0] inv, s, xb;
        for (int x = 0; x < 256; x++) begin
            xb  = x[7:0];
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(xb, y[7:0]) == 8'h01) inv = y[7:0];
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sb_t[x]  = s;
            isb_t[s] = xb;
        end
    endfunction

    function automatic ks_t expand_key(input logic [127:0] k);
        ks_t        w;
        logic [7:0] t [4];
        logic [7:0] rc, tmp;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[4*(i-1)+j];
            if (i % 4 == 0) begin
                tmp = t[0];
                t[0] = sb_t[t[1]] ^ rc;
                t[1] = sb_t[t[2]];
                t[2] = sb_t[t[3]];
                t[3] = sb_t[tmp];
                rc = gf_mul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ t[j];
        end
        return w;
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] k);
        ks_t          w;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] out;
        w = expand_key(k);
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row+4*c] = s[row+4*((c+row)%4)];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    if (r < 10)
                        s[row+4*c] = gf_mul(8'h02, t[4*c+row]) ^ gf_mul(8'h03, t[4*c+(row+1)%4])
                                   ^ t[4*c+(row+2)%4] ^ t[4*c+(row+3)%4];
                    else
                        s[row+4*c] = t[row+4*c];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    function automatic logic [127:0] model_decrypt(input logic [127:0] ct, input logic [127:0] k);
        ks_t          w;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] out;
        w = expand_key(k);
        for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ w[160+i];
        for (int r = 9; r >= 0; r--) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row+4*((c+row)%4)] = isb_t[s[row+4*c]];
            for (int i = 0; i < 16; i++) t[i] = t[i] ^ w[16*r+i];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    if (r > 0)
                        s[row+4*c] = gf_mul(8'h0e, t[4*c+row]) ^ gf_mul(8'h0b, t[4*c+(row+1)%4])
                                   ^ gf_mul(8'h0d, t[4*c+(row+2)%4]) ^ gf_mul(8'h09, t[4*c+(row+3)%4]);
                    else
                        s[row+4*c] = t[row+4*c];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction-level expectation: accept when idle, done 10 edges later.
    always @(posedge clk) begin
        if (rst) begin
            m_live = 1'b1;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_ct   = '0;
            m_left = 0;
            exp_q.delete();
            pt_q.delete();
            key_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_ct   = exp_q[0];
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_left = 10;
                exp_q.push_back(model_encrypt(plaintext, key));
                pt_q.push_back(plaintext);
                key_q.push_back(key);
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("busy", {127'b0, busy}, {127'b0, m_busy});
            check("done", {127'b0, done}, {127'b0, m_done});
            check("ciphertext", ciphertext, m_ct);
            if (m_done && exp_q.size() > 0) begin
                check("roundtrip", model_decrypt(ciphertext, key_q[0]), pt_q[0]);
                void'(exp_q.pop_front());
                void'(pt_q.pop_front());
                void'(key_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_vec(input logic [127:0] pt, input logic [127:0] k);
        start     = 1'b1;
        plaintext = pt;
        key       = k;
        @(negedge clk);
        start     = 1'b0;
        plaintext = rand128();
        key       = rand128();
    endtask

    // First `noise` cycles of the run pulse start with fresh random inputs.
    task automatic wait_done(input logic [127:0] exp_ct, input string name, input int noise);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        while (lat < 20 && !seen) begin
            if (lat < noise) begin
                start     = 1'b1;
                plaintext = rand128();
                key       = rand128();
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, lat);
        end else begin
            check({name, "_latency"}, 128'(lat), 128'd10);
            check({name, "_ct"}, ciphertext, exp_ct);
        end
    endtask

    initial begin
        int n_done;
        logic [127:0] pt_r, key_r;
        rst       = 1'b1;
        start     = 1'b0;
        plaintext = '0;
        key       = '0;
        build_tables();

        check("model_c1", model_encrypt(PT_C1, KEY_C1), CT_C1);
        check("model_b", model_encrypt(PT_B, KEY_B), CT_B);
        check("model_zero", model_encrypt('0, '0), CT_0);
        check("model_inv_b", model_decrypt(CT_B, KEY_B), PT_B);

        repeat (3) @(negedge clk);
        check("rst_busy", {127'b0, busy}, 128'd0);
        check("rst_done", {127'b0, done}, 128'd0);
        check("rst_ct", ciphertext, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        start_vec(PT_C1, KEY_C1);
        wait_done(CT_C1, "c1", 0);

        repeat (2) @(negedge clk);
        start_vec('0, '0);
        wait_done(CT_0, "zero", 0);
        start_vec(PT_C1, KEY_C1);
        wait_done(CT_C1, "b2b_c1", 0);

        @(negedge clk);
        start_vec(PT_B, KEY_B);
        wait_done(CT_B, "busy_ign", 3);
        check("appb_rk10", dut.rk_q, RK10_B);
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("extra_done", 128'(n_done), 128'd0);

        start_vec(PT_C1, KEY_C1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {127'b0, busy}, 128'd0);
        check("abort_done", {127'b0, done}, 128'd0);
        check("abort_ct", ciphertext, 128'd0);
        n_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", 128'(n_done), 128'd0);
        start_vec(PT_B, KEY_B);
        wait_done(CT_B, "after_abort", 0);

        for (int v = 0; v < 1000; v++) begin
            pt_r  = rand128();
            key_r = rand128();
            start_vec(pt_r, key_r);
            wait_done(model_encrypt(pt_r, key_r), "rand", $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_encrypt_iter.md
Name: aes_encrypt_iter

Overview:
- Iterative AES-128 encryption core (FIPS-197); the encrypt-direction counterpart of the team's unrolled decrypt datapath.
- Executes one round per clock with on-the-fly round-key expansion, so only one round's logic is instantiated.
- Sits between a host/controller (start/done handshake) and downstream consumers of the ciphertext.
- Byte order matches the decrypt path: byte 0 = bits [127:120], column-major state (bytes 0-3 form column 0).

Parameters:
- NR, 10, number of rounds (fixed for AES-128; other values unsupported, elaboration error if changed)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; sampled only when busy=0
- plaintext  input  128  block to encrypt; sampled only on the accepted start edge
- key  input  128  cipher key; sampled only on the accepted start edge
- busy  output  1  high while an encryption is in progress
- done  output  1  single-cycle pulse; ciphertext valid from this cycle
- ciphertext  output  128  result; held stable until the next done

Behaviour:
- Reset (rst=1 at an edge): busy=0, done=0, ciphertext=0, round counter=0, internal state/round-key registers=0. This takes priority over everything, including mid-operation, where the operation is aborted and no done is issued.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1, round counter 1..NR.
- Accept: edge T with start=1 and busy=0. Then state <= plaintext^key, rk <= key, rnd <= 1, go to RUN.
- RUN, edge T+r (r=1..NR):
  - rk_next = KeyStep(rk, Rcon[r]).
  - state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk_next), with MixColumns skipped when r=NR.
  - rk <= rk_next, rnd <= r+1.
- Completion, edge T+NR: ciphertext <= round result, done <= 1, busy <= 0, go to IDLE.
  - done is high for exactly the cycle after edge T+10 (latency 10 clocks from accept edge to done), then returns to 0.
- start while busy=1 is ignored: not queued, inputs not resampled.
- Back-to-back: start high in the done cycle is accepted (busy=0 then). ciphertext keeps the old value until the new done.
- plaintext/key may change freely after the accept edge without affecting the result.
- KeyStep:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon,24'h0}.
  - w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - w0 = bits [127:96].
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- MixColumns uses GF(2^8) with polynomial 0x11b.
- S-box is combinational, replicated 20x: 16 for the state, 4 for the key.

Decomposition:
- Shared package aes_pkg:
  - SBOX constant (256x8) and sbox(), xtime(), gmul2/gmul3 functions.
  - RCON array[1:10].
  - NR_128=10.
  - Helper shift_rows(), mix_columns(), key_step() functions.
- One sub-module aes_enc_round: inputs state, round_key, final_flag; output next state. Purely combinational SubBytes/ShiftRows/MixColumns/AddRoundKey.
- The FSM and key register stay in aes_encrypt_iter.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> done exactly 10 clocks after accept, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, busy high for those 10 cycles.
- FIPS-197 App B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ciphertext 3925841d02dc09fbdc118597196a0b32. Also check the internal round key after round 10 is d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key and pt -> 66e94bd4ef8a2c3b884cfa59ca342b2e. Then reassert start in the done cycle with the C.1 vector -> accepted, second done 10 clocks later with the C.1 result, ciphertext holding the zero-vector result in between.
- During busy: pulse start and change plaintext/key to random values -> ignored, result still equals the originally sampled vector, exactly one done.
- Assert rst at round 5 -> next cycle busy=0, done=0, ciphertext=0. No done follows. A fresh start then produces the correct result.
- Randomized 1000 vectors against a reference model, then feed each ciphertext to the existing decrypt block -> plaintext recovered.
